// File: rtl/drum_pkg.sv
// Shared types, widths and arithmetic helpers for the drum-grid audio path.
package drum_pkg;

    localparam int NODE_W         = 18;
    localparam int AUDIO_W        = 32;
    localparam int FRAC_SHIFT_DEF = 14;

    typedef logic signed [NODE_W-1:0]  node_t;
    typedef logic signed [AUDIO_W-1:0] audio_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        COOLDOWN = 2'd2
    } feeder_state_t;

    // Clamp a 36-bit intermediate into the signed 32-bit audio range.
    function automatic audio_t sat_audio(input logic signed [35:0] s);
        audio_t r;
        if (s[35:31] == {5{s[35]}}) begin
            r = s[31:0];
        end else if (s[35]) begin
            r = 32'sh8000_0000;
        end else begin
            r = 32'sh7FFF_FFFF;
        end
        return r;
    endfunction

    // Clamp a 21-bit intermediate into the signed 18-bit node range.
    function automatic node_t sat_node(input logic signed [20:0] v);
        node_t r;
        if (v[20:17] == {4{v[20]}}) begin
            r = v[17:0];
        end else if (v[20]) begin
            r = 18'sh2_0000;
        end else begin
            r = 18'sh1_FFFF;
        end
        return r;
    endfunction

    // Sign-extend, shift by base+g and saturate to audio width.
    function automatic audio_t scale_sample(input node_t x, input logic [1:0] g, input int base);
        logic signed [35:0] ext;
        ext = 36'(x);
        ext = ext <<< (base + 32'(g));
        return sat_audio(ext);
    endfunction

    // One first-order DC-blocker step: y = x - x_prev + y_prev - y_prev/256.
    function automatic node_t dc_step(input node_t x, input node_t x_prev, input node_t y_prev);
        logic signed [20:0] acc;
        acc = 21'(x) - 21'(x_prev) + 21'(y_prev) - 21'(y_prev >>> 8);
        return sat_node(acc);
    endfunction

endpackage

// File: rtl/drum_audio_feeder_fifo.sv
// Sample FIFO with registered pointers/occupancy; a pop on empty is ignored and a
// push on full is accepted only when a pop frees a slot in the same cycle.
module sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests against current occupancy
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (pop && (count_r != '0)) begin
            do_pop_s = 1'b1;
        end else begin
            do_pop_s = 1'b0;
        end
        if (push && ((count_r != FULL_CNT) || do_pop_s)) begin
            do_push_s = 1'b1;
        end else begin
            do_push_s = 1'b0;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata   = mem_r[rd_ptr_r];
    assign count   = count_r;
    assign empty   = (count_r == '0);
    assign dropped = push && !do_push_s;

endmodule

// File: rtl/drum_audio_feeder.sv
// Drum-grid audio feeder: captures centre-node samples, scales them into a FIFO and
// paces codec writes. Define DRUM_AUDIO_DC_BLOCK_EN to insert a DC blocker before scaling.
module drum_audio_feeder
    import drum_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [NODE_W-1:0]  node_in,
    input  logic                      node_valid,
    output logic                      step_go,
    input  logic [31:0]               pio_gain,
    input  logic                      pio_mute,
    input  logic                      audio_ready,
    output logic                      audio_write,
    output logic signed [AUDIO_W-1:0] audio_data,
    output logic [$clog2(DEPTH):0]    fill_level,
    output logic                      overflow
);
    localparam int AW = $clog2(DEPTH);

    node_t          stage_node_s;
    logic           stage_valid_s;
    logic [1:0]     stage_gain_s;
    logic           stage_mute_s;
    logic [AW+1:0]  pending_s;
    logic [AW:0]    fill_s;
    logic [29:0]    unused_gain_s;

    audio_t         cap_data_r;
    logic           cap_valid_r;
    logic           step_go_r;
    feeder_state_t  state_r;
    logic           audio_write_r;
    audio_t         audio_data_r;
    logic           overflow_r;

    audio_t         fifo_rdata_s;
    logic           fifo_empty_s;
    logic           fifo_drop_s;
    logic           pop_s;

    assign unused_gain_s = pio_gain[31:2];

`ifdef DRUM_AUDIO_DC_BLOCK_EN
    localparam logic [AW+1:0] GO_LIMIT = (AW+2)'(DEPTH-3);

    node_t      x_prev_r;
    node_t      y_prev_r;
    logic       dc_valid_r;
    logic [1:0] dc_gain_r;
    logic       dc_mute_r;

    // DC blocker state advances once per completed timestep; gain/mute ride along
    always_ff @(posedge clk) begin
        if (rst) begin
            x_prev_r   <= 18'sd0;
            y_prev_r   <= 18'sd0;
            dc_valid_r <= 1'b0;
            dc_gain_r  <= 2'd0;
            dc_mute_r  <= 1'b0;
        end else begin
            dc_valid_r <= node_valid;
            if (node_valid) begin
                x_prev_r  <= node_in;
                y_prev_r  <= dc_step(node_in, x_prev_r, y_prev_r);
                dc_gain_r <= pio_gain[1:0];
                dc_mute_r <= pio_mute;
            end
        end
    end

    // Filtered sample feeds the scaler; both pipeline stages count as in flight
    always_comb begin
        stage_node_s  = y_prev_r;
        stage_valid_s = dc_valid_r;
        stage_gain_s  = dc_gain_r;
        stage_mute_s  = dc_mute_r;
        pending_s     = (AW+2)'(fill_s) + (AW+2)'(cap_valid_r) + (AW+2)'(dc_valid_r);
    end
`else
    localparam logic [AW+1:0] GO_LIMIT = (AW+2)'(DEPTH-2);

    // Direct path: the scaler sees the grid output on the node_valid cycle
    always_comb begin
        stage_node_s  = node_in;
        stage_valid_s = node_valid;
        stage_gain_s  = pio_gain[1:0];
        stage_mute_s  = pio_mute;
        pending_s     = (AW+2)'(fill_s) + (AW+2)'(cap_valid_r);
    end
`endif

    // Capture register: scaled, saturated (or muted) sample waiting to enter the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_valid_r <= 1'b0;
            cap_data_r  <= 32'sd0;
        end else begin
            cap_valid_r <= stage_valid_s;
            if (stage_valid_s) begin
                if (stage_mute_s) begin
                    cap_data_r <= 32'sd0;
                end else begin
                    cap_data_r <= scale_sample(stage_node_s, stage_gain_s, FRAC_SHIFT);
                end
            end
        end
    end

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (AUDIO_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (cap_valid_r),
        .wdata   (cap_data_r),
        .pop     (pop_s),
        .rdata   (fifo_rdata_s),
        .count   (fill_s),
        .empty   (fifo_empty_s),
        .dropped (fifo_drop_s)
    );

    // Pop coincides with the IDLE->WRITE decision so the head is latched into audio_data
    always_comb begin
        if ((state_r == IDLE) && !fifo_empty_s && audio_ready) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Headroom gate toward the grid, counting samples still in the pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            step_go_r <= 1'b0;
        end else begin
            step_go_r <= (pending_s <= GO_LIMIT);
        end
    end

    // Codec write FSM; COOLDOWN covers the codec's one-cycle ready lag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            audio_write_r <= 1'b0;
            audio_data_r  <= 32'sd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        state_r       <= WRITE;
                        audio_write_r <= 1'b1;
                        audio_data_r  <= fifo_rdata_s;
                    end else begin
                        audio_write_r <= 1'b0;
                    end
                end
                WRITE: begin
                    state_r       <= COOLDOWN;
                    audio_write_r <= 1'b0;
                end
                COOLDOWN: begin
                    state_r       <= IDLE;
                    audio_write_r <= 1'b0;
                end
                default: begin
                    state_r       <= IDLE;
                    audio_write_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky record of samples lost to a full FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r | fifo_drop_s;
        end
    end

    assign step_go     = step_go_r;
    assign audio_write = audio_write_r;
    assign audio_data  = audio_data_r;
    assign fill_level  = fill_s;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_drum_audio_feeder.sv
// Scoreboard bench for drum_audio_feeder: stimulus pushes model predictions, a monitor
// pops and compares on every audio_write.
module tb_drum_audio_feeder;
    import drum_pkg::*;

    localparam int DEPTH = 8;
    localparam int FS    = 14;
`ifdef DRUM_AUDIO_DC_BLOCK_EN
    localparam int DC  = 1;
`else
    localparam int DC  = 0;
`endif
    localparam int LAT = 3 + DC;
    localparam longint AMAX = 64'sd2147483647;
    localparam longint AMIN = -64'sd2147483648;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [17:0] node_in = 18'sd0;
    logic               node_valid = 1'b0;
    logic               step_go;
    logic [31:0]        pio_gain = 32'd0;
    logic               pio_mute = 1'b0;
    logic               audio_ready = 1'b0;
    logic               audio_write;
    logic signed [31:0] audio_data;
    logic [3:0]         fill_level;
    logic               overflow;

    int     checks = 0;
    int     errors = 0;
    int     cycle = 0;
    int     wr_count = 0;
    int     last_wr_cycle = -100;
    logic   ready_at_edge = 1'b0;
    audio_t last_data = 32'sd0;
    longint exp_q[$];
    int     m_xp = 0;
    int     m_yp = 0;

    always #5 clk = ~clk;

    drum_audio_feeder #(.DEPTH(DEPTH), .FRAC_SHIFT(FS)) dut (
        .clk         (clk),
        .rst         (rst),
        .node_in     (node_in),
        .node_valid  (node_valid),
        .step_go     (step_go),
        .pio_gain    (pio_gain),
        .pio_mute    (pio_mute),
        .audio_ready (audio_ready),
        .audio_write (audio_write),
        .audio_data  (audio_data),
        .fill_level  (fill_level),
        .overflow    (overflow)
    );

    task automatic check(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", nm, act, act, req, req);
        end
    endtask

    // Reference: optional DC blocker in plain integers, then x * 2^(FS+g), clamp, mute.
    function automatic longint model_sample(input int x, input int g, input bit mute);
        int v;
        longint s;
        v = x;
        if (DC != 0) begin
            v = x - m_xp + m_yp - (m_yp >>> 8);
            if (v > 131071) v = 131071;
            else if (v < -131072) v = -131072;
            m_xp = x;
            m_yp = v;
        end
        s = longint'(v) * (longint'(1) << (FS + g));
        if (s > AMAX) s = AMAX;
        else if (s < AMIN) s = AMIN;
        if (mute) s = 0;
        return s;
    endfunction

    always @(posedge clk) begin
        cycle         <= cycle + 1;
        ready_at_edge <= audio_ready;
    end

    // Monitor: every write must match the oldest prediction and obey the pacing rules
    always @(negedge clk) begin
        if (rst) begin
            last_wr_cycle = -100;
        end else if (audio_write) begin
            wr_count++;
            last_data = audio_data;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=0x%0h required=no write", audio_data);
            end else begin
                check("audio_data", longint'(audio_data), exp_q.pop_front());
            end
            check("ready_before_write", longint'(ready_at_edge), 1);
            check("write_spacing_ge3", longint'(cycle - last_wr_cycle >= 3), 1);
            last_wr_cycle = cycle;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Drive one node_valid pulse; keep=0 means the sample is expected to be dropped
    task automatic pulse(input int x, input int g, input bit mute, input bit keep);
        longint e;
        node_in    = 18'(x);
        pio_gain   = ($urandom() & 32'hFFFF_FFFC) | 32'(g);
        pio_mute   = mute;
        node_valid = 1'b1;
        e = model_sample(x, g, mute);
        if (keep) exp_q.push_back(e);
        tick();
        node_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        node_valid = 1'b0;
        exp_q.delete();
        m_xp = 0;
        m_yp = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_write(input string nm, output longint d, output int lat);
        int c0;
        c0  = wr_count;
        lat = 0;
        while (wr_count == c0 && lat < 40) begin
            tick();
            lat++;
        end
        if (wr_count == c0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no write required=write within 40 cycles", nm);
        end
        d = longint'(last_data);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        audio_ready = 1'b1;
        while ((exp_q.size() != 0 || fill_level != 4'd0) && n < 3000) begin
            tick();
            n++;
        end
        repeat (6) tick();
        check({nm, "_scoreboard_empty"}, longint'(exp_q.size()), 0);
        check({nm, "_fill_zero"}, longint'(fill_level), 0);
    endtask

    initial begin
        longint d;
        int lat;
        int c0;
        int k;
        int issued;
        int n;
        longint mag;

        // Reset state
        tick();
        tick();
        check("rst_audio_write", longint'(audio_write), 0);
        check("rst_audio_data", longint'(audio_data), 0);
        check("rst_fill_level", longint'(fill_level), 0);
        check("rst_overflow", longint'(overflow), 0);
        check("rst_step_go", longint'(step_go), 0);
        rst = 1'b0;
        tick();
        check("step_go_after_rst", longint'(step_go), 1);

        // Single 0.25 sample: latency, value and exactly one strobe
        audio_ready = 1'b1;
        c0 = wr_count;
        pulse(32'h0_8000, 0, 1'b0, 1'b1);
        wait_write("first", d, lat);
        check("first_latency", longint'(1 + lat), LAT);
        check("first_data", d, 64'sh2000_0000);
        repeat (10) tick();
        check("first_single_write", longint'(wr_count - c0), 1);

        // Positive and negative saturation at g=3
        pulse(32'h1_FFFF, 3, 1'b0, 1'b1);
        wait_write("sat_pos", d, lat);
        check("sat_pos_data", d, 64'sh7FFF_FFFF);
        repeat (3) tick();
        pulse(-131072, 3, 1'b0, 1'b1);
        wait_write("sat_neg", d, lat);
        check("sat_neg_data", d, -64'sh8000_0000);
        repeat (3) tick();

        // Mute forces zero
        pulse(32'h1_0000, 0, 1'b1, 1'b1);
        wait_write("mute", d, lat);
        check("mute_data", d, 0);
        drain("directed");

        // Codec stalled: ten pulses fill to DEPTH, gate step_go, then overflow
        do_reset();
        audio_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            pulse($urandom_range(0, 262143) - 131072, $urandom_range(0, 3), 1'b0, i <= DEPTH);
            repeat (3) tick();
            k = (i < DEPTH) ? i : DEPTH;
            check("stall_fill", longint'(fill_level), k);
            check("stall_step_go", longint'(step_go), longint'(k <= DEPTH - 2 - DC));
            check("stall_overflow", longint'(overflow), longint'(i > DEPTH));
        end

        // Reset while a write is on the bus
        audio_ready = 1'b1;
        wait_write("rst_in_write", d, lat);
        rst = 1'b1;
        node_valid = 1'b0;
        exp_q.delete();
        m_xp = 0;
        m_yp = 0;
        tick();
        check("rstw_audio_write", longint'(audio_write), 0);
        check("rstw_fill_level", longint'(fill_level), 0);
        check("rstw_overflow", longint'(overflow), 0);
        rst = 1'b0;
        audio_ready = 1'b0;
        tick();

        // Full FIFO: push and pop land on the same edge
        for (int i = 0; i < DEPTH; i++) begin
            pulse($urandom_range(0, 262143) - 131072, $urandom_range(0, 3), 1'b0, 1'b1);
        end
        repeat (4) tick();
        check("full_fill", longint'(fill_level), DEPTH);
        pulse($urandom_range(0, 262143) - 131072, $urandom_range(0, 3), 1'b0, 1'b1);
        if (DC != 0) tick();
        audio_ready = 1'b1;
        tick();
        audio_ready = 1'b0;
        check("coincide_fill", longint'(fill_level), DEPTH);
        check("coincide_overflow", longint'(overflow), 0);
        tick();
        check("coincide_fill_hold", longint'(fill_level), DEPTH);
        drain("coincide");
        check("coincide_no_overflow_end", longint'(overflow), 0);

        // Randomised traffic with a grid that honours step_go
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            audio_ready = ($urandom_range(0, 3) != 0);
            if (step_go && ($urandom_range(0, 1) == 1)) begin
                int x;
                int g;
                bit m;
                x = $urandom_range(0, 262143) - 131072;
                g = $urandom_range(0, 3);
                m = ($urandom_range(0, 7) == 0);
                node_in    = 18'(x);
                pio_gain   = ($urandom() & 32'hFFFF_FFFC) | 32'(g);
                pio_mute   = m;
                node_valid = 1'b1;
                exp_q.push_back(model_sample(x, g, m));
            end else begin
                node_valid = 1'b0;
            end
            tick();
            if (overflow) check("random_no_overflow", longint'(overflow), 0);
        end
        node_valid = 1'b0;
        drain("random");
        check("random_overflow_end", longint'(overflow), 0);

`ifdef DRUM_AUDIO_DC_BLOCK_EN
        // Constant input decays through the DC blocker
        do_reset();
        audio_ready = 1'b1;
        pio_mute    = 1'b0;
        issued = 0;
        n = 0;
        while (issued < 2000 && n < 20000) begin
            if (step_go) begin
                node_in    = 18'sh0_4000;
                pio_gain   = 32'd0;
                node_valid = 1'b1;
                exp_q.push_back(model_sample(32'h4000, 0, 1'b0));
                issued++;
            end else begin
                node_valid = 1'b0;
            end
            tick();
            n++;
        end
        node_valid = 1'b0;
        check("dc_issued", longint'(issued), 2000);
        drain("dc");
        mag = (longint'(last_data) < 0) ? -longint'(last_data) : longint'(last_data);
        check("dc_decayed", longint'(mag < (longint'(256) << FS)), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
